// File: rtl/fp_types_pkg.sv
// rtl/fp_types_pkg.sv - fixed-point color types, constants and helpers
package fp_types_pkg;

    typedef logic signed [15:0] q4_12_t;

    localparam q4_12_t Q412_ONE  = 16'sh1000;
    localparam q4_12_t Q412_HALF = 16'sh0800;

    // 4x4 ordered-dither thresholds, row-major: index = {y[1:0], x[1:0]}
    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // Clamp a Q4.12 value to the unit interval; result is 0..0x1000
    function automatic logic [12:0] clamp_unorm_q412(input q4_12_t v);
        logic [12:0] r;
        if (v < 16'sd0) begin
            r = 13'd0;
        end else if (v >= Q412_ONE) begin
            r = 13'h1000;
        end else begin
            r = v[12:0];
        end
        return r;
    endfunction

    // True when clamping actually changes the value (exactly 1.0 passes untouched)
    function automatic logic is_clamped_q412(input q4_12_t v);
        return (v < 16'sd0) || (v > Q412_ONE);
    endfunction

    // Rounding offset added before the >>12: Bayer threshold centred in its bucket, or one half
    function automatic logic [11:0] dither_offset(input logic [1:0] x, input logic [1:0] y,
                                                  input logic en);
        logic [11:0] d;
        if (en) begin
            d = {BAYER4[{y, x}], 8'h80};
        end else begin
            d = Q412_HALF[11:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/fb_dither_quant_ch.sv
// rtl/fb_dither_quant_ch.sv - clamp, scale and quantize for one color channel
module fb_dither_quant_ch
    import fp_types_pkg::*;
#(
    parameter int CH_W = 5
) (
    input  q4_12_t            ch_in,
    input  logic [11:0]       dither_d,
    output logic [CH_W+11:0]  p_out,
    output logic              clamp_out,
    input  logic [CH_W+11:0]  p_in,
    output logic [CH_W-1:0]   q_out
);

    localparam int P_W = CH_W + 12;
    localparam logic [P_W-1:0] MULT = P_W'((1 << CH_W) - 1);

    logic [12:0] c;
    logic        unused_frac;

    // Front half feeds the stage-1 register; back half reads the registered product
    always_comb begin
        c         = clamp_unorm_q412(ch_in);
        clamp_out = is_clamped_q412(ch_in);
        p_out     = P_W'(c) * MULT + P_W'(dither_d);
        q_out     = p_in[P_W-1:12];
    end

    assign unused_frac = ^p_in[11:0];

endmodule

// File: rtl/fb_color_quantize.sv
// rtl/fb_color_quantize.sv - two-stage clamp/dither/RGB565 quantizer with clamp counter
module fb_color_quantize
    import fp_types_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int XY_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  q4_12_t            in_r,
    input  q4_12_t            in_g,
    input  q4_12_t            in_b,
    input  logic [XY_W-1:0]   in_x,
    input  logic [XY_W-1:0]   in_y,
    input  logic              dither_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_rgb565,
    output logic [XY_W-1:0]   out_x,
    output logic [XY_W-1:0]   out_y,
    output logic [CNT_W-1:0]  clamp_cnt,
    input  logic              clamp_cnt_clr
);

    logic              s1_valid_q, s1_valid_d;
    logic [16:0]       s1_p_r_q,   s1_p_r_d;
    logic [17:0]       s1_p_g_q,   s1_p_g_d;
    logic [16:0]       s1_p_b_q,   s1_p_b_d;
    logic [XY_W-1:0]   s1_x_q,     s1_x_d;
    logic [XY_W-1:0]   s1_y_q,     s1_y_d;

    logic              s2_valid_q, s2_valid_d;
    logic [15:0]       s2_rgb_q,   s2_rgb_d;
    logic [XY_W-1:0]   s2_x_q,     s2_x_d;
    logic [XY_W-1:0]   s2_y_q,     s2_y_d;

    logic [CNT_W-1:0]  clamp_cnt_q, clamp_cnt_d;

    logic        s1_adv;
    logic        in_fire;
    logic [11:0] dither_d;
    logic [16:0] p_r;
    logic [17:0] p_g;
    logic [16:0] p_b;
    logic        clamp_r, clamp_g, clamp_b;
    logic [4:0]  q_r;
    logic [5:0]  q_g;
    logic [4:0]  q_b;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign dither_d = dither_offset(in_x[1:0], in_y[1:0], dither_en);

    fb_dither_quant_ch #(.CH_W(5)) u_ch_r (
        .ch_in     (in_r),
        .dither_d  (dither_d),
        .p_out     (p_r),
        .clamp_out (clamp_r),
        .p_in      (s1_p_r_q),
        .q_out     (q_r)
    );

    fb_dither_quant_ch #(.CH_W(6)) u_ch_g (
        .ch_in     (in_g),
        .dither_d  (dither_d),
        .p_out     (p_g),
        .clamp_out (clamp_g),
        .p_in      (s1_p_g_q),
        .q_out     (q_g)
    );

    fb_dither_quant_ch #(.CH_W(5)) u_ch_b (
        .ch_in     (in_b),
        .dither_d  (dither_d),
        .p_out     (p_b),
        .clamp_out (clamp_b),
        .p_in      (s1_p_b_q),
        .q_out     (q_b)
    );

    // Elastic two-stage pipeline: stage 1 holds scaled products, stage 2 the packed pixel
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p_r_d   = s1_p_r_q;
        s1_p_g_d   = s1_p_g_q;
        s1_p_b_d   = s1_p_b_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        s2_rgb_d   = s2_rgb_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_p_r_d   = p_r;
            s1_p_g_d   = p_g;
            s1_p_b_d   = p_b;
            s1_x_d     = in_x;
            s1_y_d     = in_y;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_rgb_d = {q_r, q_g, q_b};
                s2_x_d   = s1_x_q;
                s2_y_d   = s1_y_q;
            end
        end
    end

    // Saturating count of accepted fragments that needed clamping; clear wins
    always_comb begin
        clamp_cnt_d = clamp_cnt_q;
        if (clamp_cnt_clr) begin
            clamp_cnt_d = '0;
        end else if (in_fire && (clamp_r || clamp_g || clamp_b) && !(&clamp_cnt_q)) begin
            clamp_cnt_d = clamp_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_p_r_q    <= '0;
            s1_p_g_q    <= '0;
            s1_p_b_q    <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_rgb_q    <= '0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            clamp_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_p_r_q    <= s1_p_r_d;
            s1_p_g_q    <= s1_p_g_d;
            s1_p_b_q    <= s1_p_b_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s2_valid_q  <= s2_valid_d;
            s2_rgb_q    <= s2_rgb_d;
            s2_x_q      <= s2_x_d;
            s2_y_q      <= s2_y_d;
            clamp_cnt_q <= clamp_cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_rgb565 = s2_rgb_q;
    assign out_x      = s2_x_q;
    assign out_y      = s2_y_q;
    assign clamp_cnt  = clamp_cnt_q;

endmodule

// File: tb/tb_fb_color_quantize.sv
// tb/tb_fb_color_quantize.sv - scoreboard bench for fb_color_quantize
module tb_fb_color_quantize;

    localparam int CNT_W = 4;
    localparam int XY_W  = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_r = '0, in_g = '0, in_b = '0;
    logic [XY_W-1:0]   in_x = '0, in_y = '0;
    logic              dither_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_rgb565;
    logic [XY_W-1:0]   out_x, out_y;
    logic [CNT_W-1:0]  clamp_cnt;
    logic              clamp_cnt_clr = 1'b0;

    fb_color_quantize #(.CNT_W(CNT_W), .XY_W(XY_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_r          (in_r),
        .in_g          (in_g),
        .in_b          (in_b),
        .in_x          (in_x),
        .in_y          (in_y),
        .dither_en     (dither_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rgb565    (out_rgb565),
        .out_x         (out_x),
        .out_y         (out_y),
        .clamp_cnt     (clamp_cnt),
        .clamp_cnt_clr (clamp_cnt_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    int or_mode = 0;
    int cyc = 0;
    int pops = 0;
    logic [35:0] exp_q[$];
    int bayer[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unit_clamp(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) return 0;
        if (s > 4096) return 4096;
        return s;
    endfunction

    function automatic bit needs_clamp(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) || (s > 4096);
    endfunction

    // Reference: clamp to [0,1], add threshold, floor(value*max + offset)
    function automatic logic [15:0] model_rgb(input logic [15:0] r, input logic [15:0] g,
                                              input logic [15:0] b, input int x, input int y,
                                              input bit den);
        int d, r5, g6, b5;
        d  = den ? bayer[y % 4][x % 4] * 256 + 128 : 2048;
        r5 = (unit_clamp(r) * 31 + d) / 4096;
        g6 = (unit_clamp(g) * 63 + d) / 4096;
        b5 = (unit_clamp(b) * 31 + d) / 4096;
        return 16'((r5 << 11) | (g6 << 5) | b5);
    endfunction

    // Downstream readiness pattern, changed just after the rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Input-side scoreboard feed and counter model
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back({model_rgb(in_r, in_g, in_b, int'(in_x), int'(in_y), dither_en),
                                 in_x, in_y});
            if (clamp_cnt_clr)
                model_cnt = 0;
            else if (in_valid && in_ready &&
                     (needs_clamp(in_r) || needs_clamp(in_g) || needs_clamp(in_b)))
                model_cnt = (model_cnt < CNT_MAX) ? model_cnt + 1 : CNT_MAX;
        end
    end

    // Output monitor: in-order data check, stall stability, counter tracking
    logic        prev_stall = 1'b0;
    logic [36:0] prev_out = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("clamp_cnt", clamp_cnt, model_cnt);
            if (prev_stall)
                chk("stall_hold", {out_valid, out_rgb565, out_x, out_y}, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out: got rgb 0x%0h x %0d y %0d with nothing expected",
                             out_rgb565, out_x, out_y);
                end else begin
                    chk("out_data", {out_rgb565, out_x, out_y}, exp_q.pop_front());
                    pops++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_rgb565, out_x, out_y};
        end
    end

    // Present one fragment from a negedge; returns at the negedge after it is accepted
    task automatic send(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                        input int x, input int y, input bit den);
        bit ok;
        in_r = r; in_g = g; in_b = b;
        in_x = x[XY_W-1:0];
        in_y = y[XY_W-1:0];
        dither_en = den;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no in_ready within 500 cycles, required accept");
        end
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
    endtask

    // Single fragment into an empty pipeline with out_ready high: checks latency and value
    task automatic directed(input string nm, input logic [15:0] r, input logic [15:0] g,
                            input logic [15:0] b, input int x, input int y, input bit den,
                            input logic [15:0] exp_rgb);
        send(r, g, b, x, y, den);
        in_valid = 1'b0;
        chk({nm, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_rgb"}, out_rgb565, exp_rgb);
        drain({nm, "_drain"});
    endtask

    function automatic logic [15:0] rand_ch();
        case ($urandom_range(0, 6))
            0:       return 16'h1000;
            1:       return 16'h0FFF;
            2:       return 16'h1001;
            3:       return 16'h0000;
            4:       return 16'hFFFF;
            5:       return 16'($urandom_range(0, 4096));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rgb", out_rgb565, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_cnt", clamp_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        directed("full_scale", 16'h1000, 16'h1000, 16'h1000, 1, 2, 1'b0, 16'hFFFF);
        chk("full_scale_cnt", clamp_cnt, 0);
        directed("midpoint", 16'h0800, 16'h0800, 16'hF000, 3, 4, 1'b0, 16'h8400);
        chk("midpoint_cnt", clamp_cnt, 1);
        directed("r_over", 16'h7FFF, 16'h0000, 16'h0000, 5, 6, 1'b0, 16'hF800);
        chk("r_over_cnt", clamp_cnt, 2);
        directed("dith_00", 16'h0800, 16'h0000, 16'h0000, 0, 0, 1'b1, 16'h7800);
        directed("dith_03", 16'h0800, 16'h0000, 16'h0000, 0, 3, 1'b1, 16'h8000);
        directed("dith_44", 16'h0800, 16'h0000, 16'h0000, 4, 4, 1'b1, 16'h7800);
        directed("dith_47", 16'h0800, 16'h0000, 16'h0000, 4, 7, 1'b1, 16'h8000);
        chk("dith_cnt", clamp_cnt, 2);

        or_mode = 1;
        p0 = pops;
        for (int i = 0; i < 8; i++)
            send(rand_ch(), rand_ch(), rand_ch(), i * 37 + 1, i * 5 + 2, 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        drain("bp_drain");
        chk("bp_count", pops - p0, 8);

        or_mode = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            send(rand_ch(), rand_ch(), rand_ch(), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        or_mode = 0;
        drain("rand_drain");

        for (int i = 0; i < 20; i++)
            send(16'h7FFF, 16'h0000, 16'h0000, i, i, 1'b0);
        in_valid = 1'b0;
        drain("sat_drain");
        chk("cnt_sat", clamp_cnt, CNT_MAX);
        clamp_cnt_clr = 1'b1;
        send(16'hF000, 16'h0000, 16'h0000, 9, 9, 1'b0);
        clamp_cnt_clr = 1'b0;
        in_valid = 1'b0;
        chk("cnt_clr", clamp_cnt, 0);
        drain("clr_drain");

        or_mode = 3;
        @(negedge clk);
        send(16'h7FFF, 16'h0000, 16'h0000, 11, 12, 1'b0);
        send(16'hF000, 16'h0000, 16'h0000, 13, 14, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_cnt", clamp_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cnt", clamp_cnt, 0);
        chk("midrst_rgb", out_rgb565, 0);
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        or_mode = 0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        repeat (10) @(negedge clk);
        directed("post_rst", 16'h1000, 16'h1000, 16'h1000, 7, 8, 1'b0, 16'hFFFF);

        drain("final_drain");
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
